// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: keycode constants, the
// keycode-to-note table and the voice allocator state encoding.
package synth_pkg;

    localparam int NOTE_W = 6;
    localparam int NUM_MAPPED = 25;

    localparam logic [7:0] KEY_NONE         = 8'h00;
    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;

    // Entry i is the keycode that plays note i (two-row piano layout).
    localparam logic [7:0] KEY_TABLE [NUM_MAPPED] = '{
        8'd53, 8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37,
        8'd38, 8'd39, 8'd45, 8'd43, 8'd20, 8'd26, 8'd8,  8'd21, 8'd23,
        8'd28, 8'd24, 8'd12, 8'd18, 8'd19, 8'd47, 8'd57
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REL   = 3'd2,
        PRESS = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/key_note_lookup.sv
// Combinational keycode-to-note translation; valid is low for unmapped
// keycodes, including the empty-slot code.
module key_note_lookup #(
    parameter int NOTE_W = synth_pkg::NOTE_W
) (
    input  logic [7:0]        keycode,
    output logic [NOTE_W-1:0] note,
    output logic              valid
);
    import synth_pkg::*;

    // Table search; table keycodes are unique so at most one entry hits.
    always_comb begin
        note  = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_MAPPED; i++) begin
            if (keycode == KEY_TABLE[i]) begin
                note  = NOTE_W'(i);
                valid = 1'b1;
            end else begin
                note  = note;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: walks each keyboard report, releases voices
// whose keys went up, then allocates (or steals) voices for new keys.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_KEYS   = 6,
    parameter int NOTE_W     = synth_pkg::NOTE_W,
    parameter int AGE_W      = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         report_valid,
    input  logic [8*NUM_KEYS-1:0]        report_keys,
    output logic                         busy,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         voice_stolen
);
    import synth_pkg::*;

    localparam int IDX_MAX = (NUM_KEYS > NUM_VOICES) ? NUM_KEYS : NUM_VOICES;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    state_t                                 state_r;
    logic [IDX_W-1:0]                       idx_r;
    logic [8*NUM_KEYS-1:0]                  cur_keys_r;
    logic [8*NUM_KEYS-1:0]                  prev_keys_r;
    logic [8*NUM_KEYS-1:0]                  pending_keys_r;
    logic                                   pending_r;
    logic                                   busy_r;
    logic [NUM_VOICES-1:0]                  gate_r;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]      note_r;
    logic [NUM_VOICES-1:0][AGE_W-1:0]       age_r;
    logic [NUM_VOICES-1:0]                  trig_r;
    logic                                   stolen_r;

    logic [NUM_KEYS-1:0][NOTE_W-1:0]        slot_note_s;
    logic [NUM_KEYS-1:0]                    slot_valid_s;
    logic [7:0]                             press_key_s;
    logic [NOTE_W-1:0]                      press_note_s;
    logic                                   press_valid_s;
    logic                                   in_prev_s;
    logic                                   rollover_s;
    logic [NOTE_W-1:0]                      rel_note_s;
    logic                                   rel_gate_s;
    logic                                   rel_present_s;
    logic                                   held_s;
    logic                                   free_found_s;
    logic [NUM_VOICES-1:0]                  free_oh_s;
    logic [NUM_VOICES-1:0]                  old_oh_s;
    logic [AGE_W-1:0]                       best_age_s;
    logic [NUM_VOICES-1:0]                  target_oh_s;
    logic                                   alloc_s;

    assign busy         = busy_r;
    assign voice_gate   = gate_r;
    assign voice_note   = note_r;
    assign voice_trig   = trig_r;
    assign voice_stolen = stolen_r;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_slot_lookup
        key_note_lookup #(.NOTE_W(NOTE_W)) u_slot (
            .keycode (cur_keys_r[8*g +: 8]),
            .note    (slot_note_s[g]),
            .valid   (slot_valid_s[g])
        );
    end

    key_note_lookup #(.NOTE_W(NOTE_W)) u_press (
        .keycode (press_key_s),
        .note    (press_note_s),
        .valid   (press_valid_s)
    );

    // Per-step operands: selected slot/voice, prior-report and rollover tests.
    always_comb begin
        press_key_s   = KEY_NONE;
        in_prev_s     = 1'b0;
        rollover_s    = 1'b0;
        rel_note_s    = '0;
        rel_gate_s    = 1'b0;
        rel_present_s = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                press_key_s = cur_keys_r[8*k +: 8];
            end else begin
                press_key_s = press_key_s;
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            in_prev_s  = in_prev_s  | (prev_keys_r[8*k +: 8] == press_key_s);
            rollover_s = rollover_s | (cur_keys_r[8*k +: 8] == KEY_ERR_ROLLOVER);
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (idx_r == IDX_W'(v)) begin
                rel_note_s = note_r[v];
                rel_gate_s = gate_r[v];
            end else begin
                rel_note_s = rel_note_s;
                rel_gate_s = rel_gate_s;
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            rel_present_s = rel_present_s |
                            (slot_valid_s[k] && (slot_note_s[k] == rel_note_s));
        end
    end

    // Allocation target: lowest free voice, else the oldest (lowest index on ties).
    always_comb begin
        held_s       = 1'b0;
        free_found_s = 1'b0;
        free_oh_s    = '0;
        best_age_s   = age_r[0];
        old_oh_s     = NUM_VOICES'(1);
        for (int v = 0; v < NUM_VOICES; v++) begin
            held_s = held_s | (gate_r[v] && (note_r[v] == press_note_s));
            if (!gate_r[v] && !free_found_s) begin
                free_found_s = 1'b1;
                free_oh_s[v] = 1'b1;
            end else begin
                free_found_s = free_found_s;
            end
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_r[v] > best_age_s) begin
                best_age_s  = age_r[v];
                old_oh_s    = '0;
                old_oh_s[v] = 1'b1;
            end else begin
                best_age_s = best_age_s;
            end
        end
        target_oh_s = free_found_s ? free_oh_s : old_oh_s;
        alloc_s     = (state_r == PRESS) && press_valid_s && !in_prev_s && !held_s;
    end

    // Report sequencer and voice state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            cur_keys_r     <= '0;
            prev_keys_r    <= '0;
            pending_keys_r <= '0;
            pending_r      <= 1'b0;
            busy_r         <= 1'b0;
            gate_r         <= '0;
            note_r         <= '0;
            age_r          <= '0;
            trig_r         <= '0;
            stolen_r       <= 1'b0;
        end else begin
            trig_r   <= '0;
            stolen_r <= 1'b0;
            // Strobes during processing are parked; the newest one wins.
            if (report_valid && (state_r != IDLE)) begin
                pending_keys_r <= report_keys;
                pending_r      <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (report_valid) begin
                        cur_keys_r <= report_keys;
                        pending_r  <= 1'b0;
                        state_r    <= CHECK;
                        busy_r     <= 1'b1;
                    end else if (pending_r) begin
                        cur_keys_r <= pending_keys_r;
                        pending_r  <= 1'b0;
                        state_r    <= CHECK;
                        busy_r     <= 1'b1;
                    end
                end
                CHECK: begin
                    idx_r <= '0;
                    if (rollover_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= REL;
                    end
                end
                REL: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if ((idx_r == IDX_W'(v)) && rel_gate_s && !rel_present_s) begin
                            gate_r[v] <= 1'b0;
                        end
                    end
                    if (idx_r == IDX_W'(NUM_VOICES - 1)) begin
                        idx_r   <= '0;
                        state_r <= PRESS;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                PRESS: begin
                    if (alloc_s) begin
                        stolen_r <= !free_found_s;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (target_oh_s[v]) begin
                                note_r[v] <= press_note_s;
                                gate_r[v] <= 1'b1;
                                trig_r[v] <= 1'b1;
                                age_r[v]  <= '0;
                            end else if (gate_r[v] && (age_r[v] != AGE_MAX)) begin
                                age_r[v] <= age_r[v] + AGE_W'(1);
                            end
                        end
                    end
                    if (idx_r == IDX_W'(NUM_KEYS - 1)) begin
                        idx_r   <= '0;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    prev_keys_r <= cur_keys_r;
                    if (report_valid) begin
                        cur_keys_r <= report_keys;
                        pending_r  <= 1'b0;
                        state_r    <= CHECK;
                    end else if (pending_r) begin
                        cur_keys_r <= pending_keys_r;
                        pending_r  <= 1'b0;
                        state_r    <= CHECK;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

endmodule
